// File: rtl/hls_run_controller.sv
// ============================================================================
// hls_run_controller
// ----------------------------------------------------------------------------
// Campaign controller for a single HLS-generated accelerator. On an accepted
// go it issues num_runs start/done handshakes back to back. It measures the
// latency of each run, keeps min/max/saturating-total statistics, and ends the
// campaign early if a run exceeds the watchdog limit.
//
// Optional feature (compile-time macro RESULT_CHECK_EN):
//   When defined, the dut_result/expected inputs and the run_pass/fail_count
//   outputs exist. Each run's result is then compared against its golden value.
//   When undefined, those ports and the compare logic are absent.
//
// Latency convention: the start cycle counts as cycle 1. A done that arrives
// in the start cycle therefore reports a latency of 1.
// ============================================================================
module hls_run_controller #(
    parameter int RUN_W          = 16,
    parameter int CYCLE_W        = 32,
`ifdef RESULT_CHECK_EN
    parameter int DATA_W         = 32,
`endif
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       go,
    input  logic [RUN_W-1:0]           num_runs,
    output logic                       dut_start_port,
    input  logic                       dut_done_port,
    output logic                       busy,
    output logic                       campaign_done,
    output logic                       timeout_flag,
    output logic [RUN_W-1:0]           run_idx,
    output logic                       result_valid,
    output logic [CYCLE_W-1:0]         last_cycles,
    output logic [CYCLE_W-1:0]         min_cycles,
    output logic [CYCLE_W-1:0]         max_cycles,
`ifdef RESULT_CHECK_EN
    input  logic [DATA_W-1:0]          dut_result,
    input  logic [DATA_W-1:0]          expected,
    output logic                       run_pass,
    output logic [RUN_W-1:0]           fail_count,
`endif
    output logic [CYCLE_W+RUN_W-1:0]   total_cycles
);

    localparam int TOT_W = CYCLE_W + RUN_W;

    // Watchdog limit in the width of the cycle counter.
    localparam logic [CYCLE_W-1:0] TIMEOUT_VAL = CYCLE_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RECORD,
        S_GAP,
        S_FINISH,
        S_TOUT
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [RUN_W-1:0]    runs_q;       // run count latched at go-accept
    logic [CYCLE_W-1:0]  cnt;          // cycles elapsed in the current run
    logic                go_accept;    // go seen while idle
    logic                done_hit;     // accelerator done inside the handshake window
    logic                last_run;     // current run is the final one
    logic [TOT_W:0]      total_sum;    // total plus this run, with a carry bit

    assign go_accept = (state == S_IDLE) && go;
    assign done_hit  = ((state == S_START) || (state == S_WAIT)) && dut_done_port;
    assign last_run  = (run_idx == (runs_q - RUN_W'(1)));
    assign total_sum = {1'b0, total_cycles} + (TOT_W + 1)'(cnt);

    // State register; a synchronous reset returns to IDLE even in the middle of a run.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) assignments so that every
        // register samples pre-edge values, independent of the order of the blocks.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the campaign sequence.
    always_comb begin
        // NOTE: the default assignment first means every path assigns state_next,
        // so no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (go) begin
                    state_next = (num_runs == '0) ? S_FINISH : S_START;
                end
            end
            S_START, S_WAIT: begin
                // If done and the watchdog coincide, done wins.
                if (dut_done_port) begin
                    state_next = S_RECORD;
                end else if (cnt == TIMEOUT_VAL) begin
                    state_next = S_TOUT;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_RECORD: begin
                state_next = last_run ? S_FINISH : S_GAP;
            end
            S_GAP:    state_next = S_START;
            S_TOUT:   state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Registered handshake and status strobes, decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            dut_start_port <= 1'b0;
            busy           <= 1'b0;
            campaign_done  <= 1'b0;
            result_valid   <= 1'b0;
        end else begin
            dut_start_port <= (state_next == S_START);
            busy           <= (state_next != S_IDLE);
            campaign_done  <= (state_next == S_FINISH);
            result_valid   <= (state_next == S_RECORD);
        end
    end

    // Campaign length capture and run index; the index advances on leaving GAP.
    always_ff @(posedge clock) begin
        if (reset) begin
            runs_q  <= '0;
            run_idx <= '0;
        end else if (go_accept) begin
            runs_q  <= num_runs;
            run_idx <= '0;
        end else if (state == S_GAP) begin
            run_idx <= run_idx + RUN_W'(1);
        end
    end

    // Per-run cycle counter: reads 1 in the start cycle and counts up while waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_next == S_START) begin
            cnt <= CYCLE_W'(1);
        end else if (state_next == S_WAIT) begin
            cnt <= cnt + CYCLE_W'(1);
        end
    end

    // Latency statistics, captured on the done cycle so they show during RECORD.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_cycles  <= '0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
        end else if (go_accept) begin
            last_cycles  <= '0;
            min_cycles   <= '1;
            max_cycles   <= '0;
            total_cycles <= '0;
        end else if (done_hit) begin
            last_cycles <= cnt;
            if (cnt < min_cycles) begin
                min_cycles <= cnt;
            end
            if (cnt > max_cycles) begin
                max_cycles <= cnt;
            end
            total_cycles <= total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
        end
    end

    // Sticky watchdog flag; cleared only by reset or a newly accepted campaign.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_flag <= 1'b0;
        end else if (go_accept) begin
            timeout_flag <= 1'b0;
        end else if (state_next == S_TOUT) begin
            timeout_flag <= 1'b1;
        end
    end

`ifdef RESULT_CHECK_EN
    logic result_match;
    assign result_match = (dut_result == expected);

    // Golden-value compare on the done cycle, with a saturating failure count.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_pass   <= 1'b0;
            fail_count <= '0;
        end else if (go_accept) begin
            run_pass   <= 1'b0;
            fail_count <= '0;
        end else if (done_hit) begin
            run_pass <= result_match;
            if (!result_match && (fail_count != '1)) begin
                fail_count <= fail_count + RUN_W'(1);
            end
        end
    end
`endif

endmodule
